// File: rtl/fetch_ifid_stage.sv
// Fetch stage: PC register, fetch addressing, IF/ID pipeline register,
// a BOOT/RUN/REDIRECT fetch FSM, saturating stall/flush counters and
// a check that redirect targets are word aligned.
module fetch_ifid_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             PC_stall,
    input  logic             IF_ID_stall,
    input  logic             IF_ID_flush,
    input  logic [31:0]      PC_add,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      imem_addr,
    output logic [31:0]      IF_ID_PC,
    output logic [31:0]      IF_ID_instr,
    output logic             IF_ID_valid,
    output logic [4:0]       IF_ID_RsA,
    output logic [4:0]       IF_ID_RsB,
    output logic             misalign_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count,
    output logic [1:0]       fetch_state
);

    typedef enum logic [1:0] {
        StBoot     = 2'd0,
        StRun      = 2'd1,
        StRedirect = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    state_e           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_ifid_pc;
    logic [31:0]      r_ifid_instr;
    logic             r_ifid_valid;
    logic             r_misalign;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    // FSM, PC, IF/ID register and event counters; flush beats both stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= StBoot;
            r_pc          <= RESET_PC;
            r_ifid_pc     <= 32'h0;
            r_ifid_instr  <= NOP_INSTR;
            r_ifid_valid  <= 1'b0;
            r_misalign    <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            case (r_state)
                StBoot: begin
                    // One idle cycle: hazard inputs ignored, IF/ID keeps the bubble
                    r_misalign <= 1'b0;
                    r_state    <= StRun;
                end
                StRun, StRedirect: begin
                    if (IF_ID_flush) begin
                        r_pc         <= {PC_add[31:2], 2'b00};
                        r_ifid_instr <= NOP_INSTR;
                        r_ifid_valid <= 1'b0;
                        r_ifid_pc    <= 32'h0;
                        r_misalign   <= (PC_add[1:0] != 2'b00);
                        if (r_flush_count != CntMax) begin
                            r_flush_count <= r_flush_count + CntOne;
                        end
                        r_state <= StRedirect;
                    end else begin
                        r_misalign <= 1'b0;
                        if (PC_stall) begin
                            if (r_stall_count != CntMax) begin
                                r_stall_count <= r_stall_count + CntOne;
                            end
                        end else begin
                            r_pc <= r_pc + PC_STEP;
                        end
                        // IF/ID stall is independent of PC stall
                        if (!IF_ID_stall) begin
                            r_ifid_instr <= imem_rdata;
                            r_ifid_pc    <= r_pc;
                            r_ifid_valid <= 1'b1;
                        end
                        r_state <= StRun;
                    end
                end
                default: begin
                    r_state <= StBoot;
                end
            endcase
        end
    end

    // Combinational outputs: fetch address and register-field slices
    always_comb begin
        imem_addr    = r_pc;
        IF_ID_PC     = r_ifid_pc;
        IF_ID_instr  = r_ifid_instr;
        IF_ID_valid  = r_ifid_valid;
        IF_ID_RsA    = r_ifid_instr[19:15];
        IF_ID_RsB    = r_ifid_instr[24:20];
        misalign_err = r_misalign;
        stall_count  = r_stall_count;
        flush_count  = r_flush_count;
        fetch_state  = r_state;
    end

endmodule

// File: doc/fetch_ifid_stage.md
Name: fetch_ifid_stage

Overview:
- PC register, instruction-fetch addressing and IF/ID pipeline register.
- Consumes PC_stall, IF_ID_stall, IF_ID_flush and PC_add from Hazard_detection_unit.
- Produces IF_ID_RsA/IF_ID_RsB, which feed back into that unit, and the IF/ID payload for decode.
- Includes a 3-state fetch FSM, saturating stall/flush event counters and redirect-alignment checking.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction written into IF/ID on flush or boot.
- PC_STEP, 4, sequential PC increment in bytes.
- CNT_W, 16, width of each event counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- PC_stall  in  1  hold PC this cycle.
- IF_ID_stall  in  1  hold IF/ID register this cycle.
- IF_ID_flush  in  1  branch redirect: load PC from PC_add, bubble IF/ID.
- PC_add  in  32  redirect target address.
- imem_rdata  in  32  instruction word at imem_addr, combinational same-cycle read.
- imem_addr  out  32  fetch address; always equals PC.
- IF_ID_PC  out  32  PC of the instruction held in IF/ID.
- IF_ID_instr  out  32  instruction held in IF/ID.
- IF_ID_valid  out  1  IF/ID holds a real instruction; 0 = bubble.
- IF_ID_RsA  out  5  IF_ID_instr[19:15].
- IF_ID_RsB  out  5  IF_ID_instr[24:20].
- misalign_err  out  1  one-cycle pulse: redirect target had PC_add[1:0] != 0.
- stall_count  out  CNT_W  cycles with PC_stall=1 while in RUN.
- flush_count  out  CNT_W  accepted redirects.
- fetch_state  out  2  FSM state: BOOT=0, RUN=1, REDIRECT=2.

Behaviour:
- Reset (rst_n low, asynchronous, any time including mid-stall or mid-redirect):
  - PC=RESET_PC, IF_ID_instr=NOP_INSTR, IF_ID_PC=0, IF_ID_valid=0.
  - misalign_err=0, both counters=0, fetch_state=BOOT.
- Outputs: all registered except imem_addr (=PC), IF_ID_RsA and IF_ID_RsB (slices of the IF_ID_instr register).
- BOOT: exactly one cycle after reset release. PC holds, IF/ID keeps bubble. Stall/flush inputs ignored; counters do not count. Next state RUN.
- RUN, per clock edge, priority flush > stall > advance:
  - IF_ID_flush=1:
    - PC <= {PC_add[31:2],2'b00}.
    - IF_ID_instr <= NOP_INSTR, IF_ID_valid <= 0, IF_ID_PC <= 0.
    - flush_count++; misalign_err <= (PC_add[1:0]!=0); next REDIRECT.
    - Flush overrides PC_stall and IF_ID_stall in the same cycle.
  - Otherwise, PC_stall=1: PC holds and stall_count++.
  - Otherwise: PC <= PC+PC_STEP, mod 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - IF_ID_stall=1 (no flush): IF/ID holds all fields.
  - Otherwise: IF_ID_instr <= imem_rdata, IF_ID_PC <= PC, IF_ID_valid <= 1.
  - PC_stall and IF_ID_stall are independent. PC_stall=1 with IF_ID_stall=0 re-captures the same PC and instruction each cycle.
- REDIRECT: one cycle.
  - Behaves as RUN for stall and advance; the target instruction is captured at the end of this cycle.
  - IF_ID_flush=1 again: new redirect accepted as in RUN, flush_count++, stay in REDIRECT.
  - Otherwise next RUN.
- misalign_err: high exactly one cycle after a misaligned redirect, else 0.
- Counters saturate at 2^CNT_W-1; no wrap.
- Latency: instruction at PC appears on IF_ID_instr 1 cycle after imem_addr=PC, absent stall or flush.
- First valid instruction after reset: IF_ID_valid rises at the 2nd rising edge after reset release, with IF_ID_PC=RESET_PC.

Test Plan:
1. Reset release, no stalls, imem_rdata=instr(PC) → IF_ID_PC = 0x0, 0x4, 0x8 on successive edges from edge 2; IF_ID_valid=1 from edge 2; fetch_state 0→1.
2. Load-use: PC_stall=IF_ID_stall=1 for 1 cycle at PC=0x8 with IF_ID_instr rs1=7 → PC stays 0x8, IF/ID unchanged, IF_ID_RsA=7 held, stall_count=1; PC=0xC next cycle.
3. Branch: IF_ID_flush=1, PC_add=0xDEADBEEC → next cycle PC=0xDEADBEEC, IF_ID_instr=0x00000013, IF_ID_valid=0, fetch_state=2, flush_count=1; following cycle IF_ID_PC=0xDEADBEEC, valid=1, state=1.
4. Flush and PC_stall both high, PC_add=0xDEADBEEF → PC=0xDEADBEEC, misalign_err=1 for one cycle, stall_count unchanged.
5. PC=0xFFFFFFFC, no stall → PC=0x00000000 next cycle; stall_count held at 0xFFFF with PC_stall=1 stays 0xFFFF.
6. rst_n low mid-REDIRECT with PC_stall=1 → immediately PC=RESET_PC, IF_ID_valid=0, counters=0, fetch_state=BOOT, without waiting for a clock edge.
